// File: rtl/multi_channel_iq_mul_acc_pkg.sv
// rtl/multi_channel_iq_mul_acc_pkg.sv - shared constants and helpers for the multi-channel IQ mul-acc
package multi_channel_iq_mul_acc_pkg;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q3 = 2'b11;
  localparam int SAT_CALC_WIDTH = 64;

  typedef enum logic {ST_ARM, ST_RUN} state_t;

  function automatic int product_width(input int adc_w, input int ref_w);
    return adc_w + ref_w;
  endfunction

  // Sum in a wide domain, then clip to the signed range of a w-bit result.
  function automatic logic signed [SAT_CALC_WIDTH-1:0] sat_add(
    input  logic signed [SAT_CALC_WIDTH-1:0] a,
    input  logic signed [SAT_CALC_WIDTH-1:0] b,
    input  int                               w,
    output logic                             clipped
  );
    logic signed [SAT_CALC_WIDTH-1:0] sum;
    logic signed [SAT_CALC_WIDTH-1:0] hi;
    logic signed [SAT_CALC_WIDTH-1:0] lo;
    sum = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    clipped = 1'b0;
    if (sum > hi) begin
      sum = hi;
      clipped = 1'b1;
    end else if (sum < lo) begin
      sum = lo;
      clipped = 1'b1;
    end
    return sum;
  endfunction

endpackage

// File: rtl/multi_channel_iq_mul_acc_channel.sv
// rtl/multi_channel_iq_mul_acc_channel.sv - one channel: product register, saturating SIN/COS accumulators, sticky clip
module iq_channel_acc
  import multi_channel_iq_mul_acc_pkg::*;
#(
  parameter int ADC_DATA_WIDTH       = 12,
  parameter int SIN_TABLE_DATA_WIDTH = 13,
  parameter int RESULT_WIDTH         = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   ce,
  input  logic                                   load,
  input  logic                                   accumulate,
  input  logic signed [ADC_DATA_WIDTH-1:0]       adc,
  input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] sin_value,
  input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] cos_value,
  output logic signed [RESULT_WIDTH-1:0]         sin_acc,
  output logic signed [RESULT_WIDTH-1:0]         cos_acc,
  output logic                                   clip
);

  localparam int PW = product_width(ADC_DATA_WIDTH, SIN_TABLE_DATA_WIDTH);

  logic signed [PW-1:0]           sin_prod;
  logic signed [PW-1:0]           cos_prod;
  logic signed [RESULT_WIDTH-1:0] sin_sum;
  logic signed [RESULT_WIDTH-1:0] cos_sum;
  logic signed [RESULT_WIDTH-1:0] sin_first;
  logic signed [RESULT_WIDTH-1:0] cos_first;
  logic                           sin_clip;
  logic                           cos_clip;
  logic                           sin_first_clip;
  logic                           cos_first_clip;

  // The first product of a result is also clipped, so narrow RESULT_WIDTH cannot wrap.
  always_comb begin
    sin_clip       = 1'b0;
    cos_clip       = 1'b0;
    sin_first_clip = 1'b0;
    cos_first_clip = 1'b0;
    sin_sum   = RESULT_WIDTH'(sat_add(SAT_CALC_WIDTH'(sin_acc), SAT_CALC_WIDTH'(sin_prod),
                                      RESULT_WIDTH, sin_clip));
    cos_sum   = RESULT_WIDTH'(sat_add(SAT_CALC_WIDTH'(cos_acc), SAT_CALC_WIDTH'(cos_prod),
                                      RESULT_WIDTH, cos_clip));
    sin_first = RESULT_WIDTH'(sat_add('0, SAT_CALC_WIDTH'(sin_prod), RESULT_WIDTH, sin_first_clip));
    cos_first = RESULT_WIDTH'(sat_add('0, SAT_CALC_WIDTH'(cos_prod), RESULT_WIDTH, cos_first_clip));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_prod <= '0;
      cos_prod <= '0;
      sin_acc  <= '0;
      cos_acc  <= '0;
      clip     <= 1'b0;
    end else if (ce) begin
      sin_prod <= PW'(adc) * PW'(sin_value);
      cos_prod <= PW'(adc) * PW'(cos_value);
      if (load) begin
        sin_acc <= sin_first;
        cos_acc <= cos_first;
        clip    <= sin_first_clip | cos_first_clip;
      end else if (accumulate) begin
        sin_acc <= sin_sum;
        cos_acc <= cos_sum;
        clip    <= clip | sin_clip | cos_clip;
      end
    end
  end

endmodule

// File: rtl/multi_channel_iq_mul_acc.sv
// rtl/multi_channel_iq_mul_acc.sv - multi-channel ADC x SIN/COS multiply-accumulate over DCO periods with result handshake
module multi_channel_iq_mul_acc
  import multi_channel_iq_mul_acc_pkg::*;
#(
  parameter int CHANNELS             = 2,
  parameter int ADC_DATA_WIDTH       = 12,
  parameter int SIN_TABLE_DATA_WIDTH = 13,
  parameter int RESULT_WIDTH         = 32,
  parameter int PERIOD_COUNT_BITS    = 4
) (
  input  logic                                   CLK,
  input  logic                                   RESET_N,
  input  logic                                   CE,
  input  logic [1:0]                             PHASE_QUADRANT,
  input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] SIN_VALUE,
  input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] COS_VALUE,
  input  logic [CHANNELS*ADC_DATA_WIDTH-1:0]     ADC_VALUES,
  input  logic [PERIOD_COUNT_BITS-1:0]           PERIODS,
  input  logic                                   RESULT_READY,
  output logic                                   RESULT_VALID,
  output logic [CHANNELS*RESULT_WIDTH-1:0]       SIN_RESULT,
  output logic [CHANNELS*RESULT_WIDTH-1:0]       COS_RESULT,
  output logic [CHANNELS-1:0]                    SATURATED,
  output logic                                   OVERRUN
);

  logic [1:0]                             quad_r;
  logic [1:0]                             quad_prev;
  logic signed [SIN_TABLE_DATA_WIDTH-1:0] sin_r;
  logic signed [SIN_TABLE_DATA_WIDTH-1:0] cos_r;
  logic [CHANNELS*ADC_DATA_WIDTH-1:0]     adc_r;
  logic                                   bnd_prod;

  state_t                         state;
  logic [PERIOD_COUNT_BITS-1:0]   cnt;
  logic [PERIOD_COUNT_BITS-1:0]   last_cnt;
  logic                           bnd_in;
  logic                           at_last;
  logic                           capture;
  logic                           load;
  logic                           accumulate;

  logic signed [RESULT_WIDTH-1:0] sin_acc [CHANNELS];
  logic signed [RESULT_WIDTH-1:0] cos_acc [CHANNELS];
  logic [CHANNELS-1:0]            clip;

  always_comb begin
    bnd_in     = (quad_prev == Q3) && (quad_r == Q0);
    last_cnt   = (PERIODS == '0) ? '0 : PERIODS - PERIOD_COUNT_BITS'(1);
    at_last    = (cnt >= last_cnt);
    capture    = (state == ST_RUN) && bnd_prod && at_last;
    load       = bnd_prod && ((state == ST_ARM) || at_last);
    accumulate = (state == ST_RUN) && !load;
  end

  // bnd_prod travels with the product register so it marks the boundary product itself.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      quad_r    <= '0;
      quad_prev <= '0;
      sin_r     <= '0;
      cos_r     <= '0;
      adc_r     <= '0;
      bnd_prod  <= 1'b0;
    end else if (CE) begin
      quad_r    <= PHASE_QUADRANT;
      quad_prev <= quad_r;
      sin_r     <= SIN_VALUE;
      cos_r     <= COS_VALUE;
      adc_r     <= ADC_VALUES;
      bnd_prod  <= bnd_in;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    iq_channel_acc #(
      .ADC_DATA_WIDTH      (ADC_DATA_WIDTH),
      .SIN_TABLE_DATA_WIDTH(SIN_TABLE_DATA_WIDTH),
      .RESULT_WIDTH        (RESULT_WIDTH)
    ) u_acc (
      .clk       (CLK),
      .rst_n     (RESET_N),
      .ce        (CE),
      .load      (load),
      .accumulate(accumulate),
      .adc       (adc_r[g*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]),
      .sin_value (sin_r),
      .cos_value (cos_r),
      .sin_acc   (sin_acc[g]),
      .cos_acc   (cos_acc[g]),
      .clip      (clip[g])
    );
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= ST_ARM;
      cnt          <= '0;
      RESULT_VALID <= 1'b0;
      SIN_RESULT   <= '0;
      COS_RESULT   <= '0;
      SATURATED    <= '0;
      OVERRUN      <= 1'b0;
    end else if (CE) begin
      case (state)
        ST_ARM: begin
          if (bnd_prod) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        default: begin
          if (bnd_prod) cnt <= at_last ? '0 : cnt + PERIOD_COUNT_BITS'(1);
        end
      endcase
      if (capture) begin
        for (int c = 0; c < CHANNELS; c++) begin
          SIN_RESULT[c*RESULT_WIDTH +: RESULT_WIDTH] <= sin_acc[c];
          COS_RESULT[c*RESULT_WIDTH +: RESULT_WIDTH] <= cos_acc[c];
        end
        SATURATED    <= clip;
        RESULT_VALID <= 1'b1;
        if (RESULT_VALID && !RESULT_READY) OVERRUN <= 1'b1;
      end else if (RESULT_VALID && RESULT_READY) begin
        RESULT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: doc/multi_channel_iq_mul_acc.md
Name: multi_channel_iq_mul_acc

Overview:
- Multi-channel successor to the single-channel quadrant mul-acc stage in the ADC/DAC frontend.
- Multiplies CHANNELS simultaneously sampled ADC inputs by a shared SIN/COS reference from the DCO.
- Accumulates each product over a programmable number of DCO periods, with saturation.
- Presents per-channel SIN/COS sums through a valid/ready output register with overrun detection. Sits between sin_cos_dco and the per-channel result IIR filters.

Parameters:
CHANNELS, 2, number of ADC channels processed in parallel
ADC_DATA_WIDTH, 12, signed ADC sample width
SIN_TABLE_DATA_WIDTH, 13, signed SIN/COS reference width
RESULT_WIDTH, 32, signed accumulator/result width per channel per component
PERIOD_COUNT_BITS, 4, width of PERIODS input

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous reset, active-low
CE  in  1  clock enable; 0 freezes all state including handshake
PHASE_QUADRANT  in  2  top two bits of DCO phase, aligned with SIN_VALUE/COS_VALUE
SIN_VALUE  in  SIN_TABLE_DATA_WIDTH  signed reference sine
COS_VALUE  in  SIN_TABLE_DATA_WIDTH  signed reference cosine
ADC_VALUES  in  CHANNELS*ADC_DATA_WIDTH  packed signed samples, ch0 in LSBs
PERIODS  in  PERIOD_COUNT_BITS  DCO periods per result; 0 treated as 1
RESULT_READY  in  1  consumer accepts result
RESULT_VALID  out  1  result register holds unconsumed data
SIN_RESULT  out  CHANNELS*RESULT_WIDTH  packed signed sum ADC*SIN
COS_RESULT  out  CHANNELS*RESULT_WIDTH  packed signed sum ADC*COS
SATURATED  out  CHANNELS  per-channel flag: either sum of current result clipped
OVERRUN  out  1  sticky: an unconsumed result was overwritten

Behaviour:
- Reset (RESET_N low, async): all outputs 0; accumulators 0; period counter 0; state ARM.
- All state updates only when CE=1.
- Pipeline:
  - Edge 1 registers inputs.
  - Edge 2 forms signed products, width ADC_DATA_WIDTH+SIN_TABLE_DATA_WIDTH.
  - Edge 3 accumulates/captures.
- Boundary: registered PHASE_QUADRANT transitions 2'b11 -> 2'b00. The boundary flag is delayed 2 stages to align with its product. The boundary sample belongs to the new period.
- States:
  - ARM: discard products until first aligned boundary. Then acc <= product, cnt <= 0, go RUN.
  - RUN, non-boundary: acc <= sat(acc + sext(product)).
  - RUN, boundary with cnt == max(PERIODS,1)-1: result register <= acc (SATURATED per channel <= sticky clip flags); acc <= product; clip flags cleared; cnt <= 0.
  - RUN, boundary otherwise: cnt <= cnt+1; accumulate normally.
- PERIODS is compared live. A change mid-result takes effect on the next boundary. If cnt already >= new PERIODS-1, capture occurs at the next boundary.
- Saturation: sum clipped to [-2^(RESULT_WIDTH-1), 2^(RESULT_WIDTH-1)-1]. The clip sets that channel's sticky flag; the flag is cleared on capture.
- Handshake:
  - RESULT_VALID rises the cycle a capture occurs (3 edges after the boundary sample is presented).
  - Data is stable while VALID=1 until VALID&&READY&&CE.
  - Capture with VALID=1, no acceptance: data overwritten, VALID stays 1, OVERRUN <= 1.
  - Capture in the same cycle as acceptance: new data loaded, VALID stays 1, no overrun.
  - OVERRUN clears only on reset.
- Latency: products of input at cycle t are included in the accumulator after edge t+3.

Decomposition:
- Shared package: quadrant encoding constants (Q0=2'b00, Q3=2'b11), a saturating-add function, and the product-width formula.
- One natural sub-module: iq_channel_acc (one channel; multiply, saturating accumulate, clip flags), instantiated CHANNELS times by generate.
- The top level owns boundary detection, ARM/RUN FSM, period counter and output handshake.

Test Plan:
- Const ch0=100, ch1=-100, SIN=2, COS=-3, quadrant stepping 8 samples/period, PERIODS=1, READY=1 -> every 8 cycles VALID pulses; SIN_RESULT ch0=1600, ch1=-1600; COS_RESULT ch0=-2400, ch1=2400; SATURATED=0.
- Same stimulus, PERIODS=3 -> VALID every 24 cycles, ch0 SIN=4800, COS=-7200; PERIODS=0 behaves as 1.
- RESULT_WIDTH=16, ADC=2047, SIN=4095, 8-sample periods -> SIN_RESULT ch0=32767, SATURATED[0]=1; next clean result (ADC=1) clears flag.
- READY=0 for two captures -> VALID=1, data equals second result, OVERRUN=1; READY pulse on the capture cycle -> no overrun.
- CE=0 for 5 cycles mid-period -> results identical to uninterrupted run shifted by 5 cycles; VALID/data unchanged during freeze.
- RESET_N low mid-period asynchronously -> outputs 0 immediately; after release, first result only after one full PERIODS span following the first boundary (ARM discards partial period).
